dot_product_feeder: RTL and testbench

DOT_PRODUCT_FEEDER -- requirements
Module: dot_product_feeder

---
 rtl/qr_pkg.sv | 35 +++
 rtl/dot_product.sv | 55 +++++
 rtl/dot_product_feeder.sv | 154 +++++++++++++++
 tb/tb_dot_product_feeder.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qr_pkg.sv
// -----------------------------------------------------------------------------
// qr_pkg
// Shared widths, the feeder FSM state encoding and a saturating negate helper
// used by dot_product_feeder and dot_product.
// -----------------------------------------------------------------------------
package qr_pkg;

  localparam int DATA_W = 28;  // element width (signed)
  localparam int PROD_W = 56;  // product / accumulator width (signed)
  localparam int VEC_N  = 4;   // elements per vector
  localparam int CNT_W  = 2;   // width of the beat counter (0..VEC_N-1)

  typedef enum logic [1:0] {
    LOAD = 2'd0,  // collecting element pairs
    CALC = 2'd1,  // dot_product pipeline evaluating the buffers
    HOLD = 2'd2   // result presented, waiting for out_ready
  } state_e;

  // Two's complement negate that clamps the single overflow case
  // -(-2^(DATA_W-1)) to the largest positive value.
  function automatic logic [DATA_W-1:0] neg_sat(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] most_neg;
    most_neg = {1'b1, {(DATA_W-1){1'b0}}};
    if (x == most_neg) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
    return (~x) + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

  // Sign-extend one element to accumulator width.
  function automatic logic [PROD_W-1:0] sext(input logic [DATA_W-1:0] x);
    return {{(PROD_W-DATA_W){x[DATA_W-1]}}, x};
  endfunction

endpackage

// File: rtl/dot_product.sv
// -----------------------------------------------------------------------------
// dot_product
// Complex dot product sum_k A[k]*B[k] over VEC_N elements, with one register
// stage on the result. Arithmetic is modulo 2^PROD_W (two's complement wrap).
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   a_re_i, a_im_i VEC_N signed elements of A (real / imaginary)
//   b_re_i, b_im_i VEC_N signed elements of B (real / imaginary)
//   sum_re_o       registered real part of the dot product
//   sum_im_o       registered imaginary part of the dot product
// -----------------------------------------------------------------------------
module dot_product
  import qr_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [VEC_N-1:0][DATA_W-1:0]   a_re_i,
  input  logic [VEC_N-1:0][DATA_W-1:0]   a_im_i,
  input  logic [VEC_N-1:0][DATA_W-1:0]   b_re_i,
  input  logic [VEC_N-1:0][DATA_W-1:0]   b_im_i,
  output logic [PROD_W-1:0]              sum_re_o,
  output logic [PROD_W-1:0]              sum_im_o
);

  logic [PROD_W-1:0] sum_re_d, sum_im_d;
  logic [PROD_W-1:0] sum_re_q, sum_im_q;

  // Operands are sign-extended to PROD_W, so an unsigned PROD_W-bit multiply
  // yields the correct signed product modulo 2^PROD_W.
  always_comb begin
    sum_re_d = '0;
    sum_im_d = '0;
    for (int k = 0; k < VEC_N; k++) begin
      sum_re_d = sum_re_d + sext(a_re_i[k]) * sext(b_re_i[k])
                          - sext(a_im_i[k]) * sext(b_im_i[k]);
      sum_im_d = sum_im_d + sext(a_re_i[k]) * sext(b_im_i[k])
                          + sext(a_im_i[k]) * sext(b_re_i[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_re_q <= '0;
      sum_im_q <= '0;
    end else begin
      sum_re_q <= sum_re_d;
      sum_im_q <= sum_im_d;
    end
  end

  assign sum_re_o = sum_re_q;
  assign sum_im_o = sum_im_q;

endmodule

// File: rtl/dot_product_feeder.sv
// -----------------------------------------------------------------------------
// dot_product_feeder
// Collects VEC_N complex element pairs (A[k], B[k]), optionally conjugating the
// A element per beat, runs them through dot_product and presents the 56-bit
// complex result until downstream takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// 1; valid, once raised by the producer, is expected to hold its data until
// that edge, and ready may depend combinationally only on clear and state.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   clear                  synchronous abort back to empty LOAD
//   in_valid / in_ready    element-pair handshake (in_ready only in LOAD)
//   in_real_a, in_imag_a   signed element of A
//   in_real_b, in_imag_b   signed element of B
//   conj_a                 per-beat: store conj(A element)
//   out_valid / out_ready  result handshake (out_valid only in HOLD)
//   out_real, out_imag     signed result, wraps modulo 2^56
//   busy                   high unless idle in LOAD with no beats stored
//   dbg_state, dbg_count   current FSM state and beat counter
// -----------------------------------------------------------------------------
module dot_product_feeder
  import qr_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_real_a,
  input  logic [DATA_W-1:0] in_imag_a,
  input  logic [DATA_W-1:0] in_real_b,
  input  logic [DATA_W-1:0] in_imag_b,
  input  logic              conj_a,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] out_real,
  output logic [PROD_W-1:0] out_imag,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [CNT_W-1:0]  dbg_count
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              beat_fire;
  logic              capture;

  logic [VEC_N-1:0][DATA_W-1:0] a_re_q, a_im_q, b_re_q, b_im_q;
  logic [PROD_W-1:0]            out_real_q, out_imag_q;
  logic [PROD_W-1:0]            dp_re, dp_im;

  assign in_ready  = (state_q == LOAD) && !clear;
  assign beat_fire = in_valid && in_ready;

  // In CALC the counter is reused as a phase: phase 0 lets the operands reach
  // the dot_product register, phase 1 captures its output and moves to HOLD.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    capture = 1'b0;
    case (state_q)
      LOAD: begin
        if (beat_fire) begin
          if (count_q == CNT_W'(VEC_N-1)) begin
            state_d = CALC;
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      CALC: begin
        if (count_q == '0) begin
          count_d = CNT_W'(1);
        end else begin
          count_d = '0;
          state_d = HOLD;
          capture = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
        count_d = '0;
      end
    endcase
    // clear wins over any beat or result handshake and leaves the result
    // registers untouched.
    if (clear) begin
      state_d = LOAD;
      count_d = '0;
      capture = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_re_q <= '0;
      a_im_q <= '0;
      b_re_q <= '0;
      b_im_q <= '0;
    end else if (beat_fire) begin
      a_re_q[count_q] <= in_real_a;
      a_im_q[count_q] <= conj_a ? neg_sat(in_imag_a) : in_imag_a;
      b_re_q[count_q] <= in_real_b;
      b_im_q[count_q] <= in_imag_b;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_real_q <= '0;
      out_imag_q <= '0;
    end else if (capture) begin
      out_real_q <= dp_re;
      out_imag_q <= dp_im;
    end
  end

  dot_product u_dot_product (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_re_i   (a_re_q),
    .a_im_i   (a_im_q),
    .b_re_i   (b_re_q),
    .b_im_i   (b_im_q),
    .sum_re_o (dp_re),
    .sum_im_o (dp_im)
  );

  assign out_valid = (state_q == HOLD);
  assign out_real  = out_real_q;
  assign out_imag  = out_imag_q;
  assign busy      = !((state_q == LOAD) && (count_q == '0));
  assign dbg_state = state_q;
  assign dbg_count = count_q;

endmodule

// File: tb/tb_dot_product_feeder.sv
module tb_dot_product_feeder;
  import qr_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [27:0] in_real_a = '0, in_imag_a = '0, in_real_b = '0, in_imag_b = '0;
  logic        conj_a = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [55:0] out_real, out_imag;
  logic        busy;
  logic [1:0]  dbg_state;
  logic [1:0]  dbg_count;

  dot_product_feeder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real_a (in_real_a),
    .in_imag_a (in_imag_a),
    .in_real_b (in_real_b),
    .in_imag_b (in_imag_b),
    .conj_a    (conj_a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .busy      (busy),
    .dbg_state (dbg_state),
    .dbg_count (dbg_count)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int failures = 0;
  logic [111:0] exp_q[$];

  localparam longint MAXV = (longint'(1) << 27) - 1;
  localparam logic [27:0] MOST_NEG = 28'h8000000;

  // Stimulus for one vector
  logic [27:0] v_ar[4], v_ai[4], v_br[4], v_bi[4];
  logic        v_cj[4];
  // Behavioural model: the values the block should hold per element
  longint m_ar[4], m_ai[4], m_br[4], m_bi[4];
  logic [55:0] got_re, got_im;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input logic [27:0] x);
    return longint'(signed'(x));
  endfunction

  function automatic logic [27:0] rnd28();
    case ($urandom_range(0, 4))
      0:       return MOST_NEG;
      1:       return 28'h7FFFFFF;
      2:       return 28'($urandom_range(0, 15)) - 28'd8;
      default: return 28'($urandom);
    endcase
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic send_beat(input int k);
    bit     acc;
    longint a_im;
    a_im = sx(v_ai[k]);
    if (v_cj[k]) begin
      a_im = -a_im;
      if (a_im > MAXV) a_im = MAXV;
    end
    m_ar[k] = sx(v_ar[k]); m_ai[k] = a_im;
    m_br[k] = sx(v_br[k]); m_bi[k] = sx(v_bi[k]);
    in_real_a = v_ar[k]; in_imag_a = v_ai[k];
    in_real_b = v_br[k]; in_imag_b = v_bi[k];
    conj_a = v_cj[k];
    in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      if (in_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) check("beat_accept_timeout", 0, 1);
  endtask

  task automatic push_expected();
    longint re, im;
    re = 0; im = 0;
    for (int k = 0; k < 4; k++) begin
      re += m_ar[k] * m_br[k] - m_ai[k] * m_bi[k];
      im += m_ar[k] * m_bi[k] + m_ai[k] * m_br[k];
    end
    exp_q.push_back({re[55:0], im[55:0]});
  endtask

  task automatic send_vector(input int max_gap);
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
      send_beat(k);
    end
    push_expected();
  endtask

  task automatic collect(input int stall, input bit chk_lat);
    int           lat;
    logic [111:0] e;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    check("out_valid_seen", out_valid, 1);
    if (chk_lat) check("latency_edges", lat, 2);
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    check("out_real", out_real, e[111:56]);
    check("out_imag", out_imag, e[55:0]);
    got_re = out_real; got_im = out_imag;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1;
      in_real_a = rnd28(); in_real_b = rnd28();
      @(posedge clk); #1;
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
      check("hold_count", dbg_count, 0);
      check("hold_real", out_real, e[111:56]);
      check("hold_imag", out_imag, e[55:0]);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_state", dbg_state, LOAD);
    check("ret_out_valid", out_valid, 0);
    check("ret_busy", busy, 0);
    check("ret_in_ready", in_ready, 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    // reset values, no edge required
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, LOAD);
    check("rst_count", dbg_count, 0);
    check("rst_out_real", out_real, 0);
    check("rst_out_imag", out_imag, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // integer vector 1..4 dotted with itself
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = 28'(k + 1); v_ai[k] = '0; v_br[k] = 28'(k + 1); v_bi[k] = '0; v_cj[k] = 1'b0;
    end
    send_vector(0);
    collect(0, 1);
    check("basic_re_30", got_re, 56'd30);
    check("basic_im_0", got_im, 56'd0);

    // purely imaginary vectors, with and without conjugation
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = '0; v_ai[k] = 28'd1; v_br[k] = '0; v_bi[k] = 28'd1; v_cj[k] = 1'b1;
    end
    send_vector(1);
    collect(0, 1);
    check("conj_re_4", got_re, 56'd4);
    check("conj_im_0", got_im, 56'd0);
    for (int k = 0; k < 4; k++) v_cj[k] = 1'b0;
    send_vector(1);
    collect(0, 1);
    check("noconj_re_m4", got_re, {56{1'b1}} - 56'd3);

    // result held while downstream stalls and input keeps offering beats
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = rnd28(); v_ai[k] = rnd28(); v_br[k] = rnd28(); v_bi[k] = rnd28();
      v_cj[k] = 1'($urandom_range(0, 1));
    end
    send_vector(0);
    collect(10, 1);

    // clear with a simultaneous beat after two beats
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = rnd28(); v_ai[k] = rnd28(); v_br[k] = rnd28(); v_bi[k] = rnd28(); v_cj[k] = 1'b0;
    end
    send_beat(0);
    send_beat(1);
    check("pre_clear_count", dbg_count, 2);
    clear = 1'b1; in_valid = 1'b1;
    #1;
    check("clear_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clear_count", dbg_count, 0);
    check("clear_busy", busy, 0);
    check("clear_state", dbg_state, LOAD);
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = rnd28(); v_ai[k] = rnd28(); v_br[k] = rnd28(); v_bi[k] = rnd28();
      v_cj[k] = 1'($urandom_range(0, 1));
    end
    send_vector(2);
    collect(0, 1);

    // accumulator wrap
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = MOST_NEG; v_ai[k] = '0; v_br[k] = MOST_NEG; v_bi[k] = '0; v_cj[k] = 1'b0;
    end
    send_vector(0);
    collect(0, 1);
    check("wrap_re_0", got_re, 56'd0);

    // conjugate saturation of the most negative imaginary part
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = '0; v_ai[k] = MOST_NEG; v_br[k] = 28'd1; v_bi[k] = '0; v_cj[k] = 1'b1;
    end
    send_vector(0);
    collect(0, 1);
    check("sat_im", got_im, 56'(4 * MAXV));
    check("sat_re", got_re, 56'd0);

    // randomized vectors with idle gaps and stalls
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 4; k++) begin
        v_ar[k] = rnd28(); v_ai[k] = rnd28(); v_br[k] = rnd28(); v_bi[k] = rnd28();
        v_cj[k] = 1'($urandom_range(0, 1));
      end
      send_vector(3);
      collect($urandom_range(0, 3), 1);
    end

    // asynchronous reset while in CALC
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = rnd28(); v_ai[k] = rnd28(); v_br[k] = rnd28(); v_bi[k] = rnd28(); v_cj[k] = 1'b0;
    end
    send_vector(0);
    check("calc_state", dbg_state, CALC);
    check("calc_out_valid", out_valid, 0);
    rst_n = 1'b0;
    #1;
    check("arst_state", dbg_state, LOAD);
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_out_real", out_real, 0);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    check("arst_hold_valid", out_valid, 0);
    rst_n = 1'b1;
    #1;

    // recovery after reset
    for (int k = 0; k < 4; k++) begin
      v_ar[k] = rnd28(); v_ai[k] = rnd28(); v_br[k] = rnd28(); v_bi[k] = rnd28();
      v_cj[k] = 1'($urandom_range(0, 1));
    end
    send_vector(1);
    collect(2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
